test_result_monitor: RTL and testbench

- Synthesisable, parametrised end-of-test monitor for one or more riscv_core harts.
- Snoops each hart's register-file writeback port and shadows the done, pass and test-id registers.
- Runs a cycle counter and a timeout watchdog, waits a settle window after all harts finish, then latches a sticky PASS/FAIL/TIMEOUT verdict.
- Lets the core tb, and FPGA builds without a simulator, report results from hardware signals instead of hierarchical peeks.

---
 rtl/test_result_monitor.sv | 199 +++++++++++++++++++
 tb/tb_test_result_monitor.sv | 611 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_result_monitor.sv
// test_result_monitor: end-of-test verdict monitor for riscv_core harts.
// Shadows done/pass/id writebacks and latches a sticky PASS/FAIL/TIMEOUT.
module test_result_monitor #(
  parameter int NUM_HART    = 1,
  parameter int XLEN        = 32,
  parameter int DONE_REG    = 26,
  parameter int PASS_REG    = 27,
  parameter int ID_REG      = 3,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr_i,
  input  logic [NUM_HART-1:0]      wb_we_i,
  input  logic [NUM_HART*5-1:0]    wb_waddr_i,
  input  logic [NUM_HART*XLEN-1:0] wb_wdata_i,
  output logic [2:0]               state_o,
  output logic                     finished_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     timeout_o,
  output logic [NUM_HART-1:0]      fail_mask_o,
  output logic [XLEN-1:0]          fail_id_o,
  output logic [NUM_HART-1:0]      done_mask_o,
  output logic [CNT_W-1:0]         cycle_cnt_o
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam int SW =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SET_LD =
    SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0] SET_ONE =
    {{(SW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TO_LIM =
    CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ONE =
    {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [4:0] DONE_A = DONE_REG[4:0];
  localparam logic [4:0] PASS_A = PASS_REG[4:0];
  localparam logic [4:0] ID_A   = ID_REG[4:0];

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [SW-1:0]                 settle_q, settle_d;
  logic [NUM_HART-1:0]           done_q, done_d, done_w;
  logic [NUM_HART-1:0]           psh_q, psh_d, psh_w;
  logic [NUM_HART-1:0][XLEN-1:0] id_q, id_d, id_w;
  logic [NUM_HART-1:0]           fmask_q, fmask_d;
  logic [XLEN-1:0]               fid_q, fid_d, low_id;
  logic                          fin_q, fin_d;
  logic                          ps_q, ps_d;
  logic                          fl_q, fl_d;
  logic                          to_q, to_d;
  logic                          live;
  logic                          to_hit;

  assign live   = (state_q == ST_RUN) ||
                  (state_q == ST_SETTLE);
  assign to_hit = (cnt_q == TO_LIM);

  // Snoop writeback ports; terminal states freeze the shadows.
  always_comb begin
    done_w = done_q;
    psh_w  = psh_q;
    id_w   = id_q;
    for (int h = 0; h < NUM_HART; h++) begin
      if (live && wb_we_i[h] &&
          (wb_waddr_i[5*h +: 5] != 5'd0)) begin
        if (wb_waddr_i[5*h +: 5] == ID_A)
          id_w[h] = wb_wdata_i[XLEN*h +: XLEN];
        if (wb_waddr_i[5*h +: 5] == PASS_A)
          psh_w[h] =
            (wb_wdata_i[XLEN*h +: XLEN] == ONE);
        if ((wb_waddr_i[5*h +: 5] == DONE_A) &&
            (wb_wdata_i[XLEN*h +: XLEN] == ONE))
          done_w[h] = 1'b1;
      end
    end
  end

  // Test id of the lowest-index hart whose pass flag is clear.
  always_comb begin
    low_id = '0;
    for (int h = NUM_HART - 1; h >= 0; h--) begin
      if (!psh_w[h])
        low_id = id_w[h];
    end
  end

  // Verdict FSM, saturating cycle counter and synchronous clear.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    fmask_d  = fmask_q;
    fid_d    = fid_q;
    done_d   = done_w;
    psh_d    = psh_w;
    id_d     = id_w;
    if (live && !to_hit && (cnt_q != '1))
      cnt_d = cnt_q + CNT_ONE;
    case (state_q)
      ST_RUN: begin
        if (to_hit) begin
          state_d = ST_TIMEOUT;
        end else if (&done_w) begin
          state_d  = ST_SETTLE;
          settle_d = SET_LD;
        end
      end
      ST_SETTLE: begin
        if (to_hit) begin
          state_d = ST_TIMEOUT;
        end else if (settle_q == '0) begin
          if (&psh_w) begin
            state_d = ST_PASS;
          end else begin
            state_d = ST_FAIL;
            fmask_d = ~psh_w;
            fid_d   = low_id;
          end
        end else begin
          settle_d = settle_q - SET_ONE;
        end
      end
      default: ;
    endcase
    if (clr_i) begin
      state_d  = ST_RUN;
      cnt_d    = '0;
      settle_d = '0;
      fmask_d  = '0;
      fid_d    = '0;
      done_d   = '0;
      psh_d    = '0;
      id_d     = '0;
    end
    fin_d = (state_d == ST_PASS) ||
            (state_d == ST_FAIL) ||
            (state_d == ST_TIMEOUT);
    ps_d  = (state_d == ST_PASS);
    fl_d  = (state_d == ST_FAIL);
    to_d  = (state_d == ST_TIMEOUT);
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      settle_q <= '0;
      done_q   <= '0;
      psh_q    <= '0;
      id_q     <= '0;
      fmask_q  <= '0;
      fid_q    <= '0;
      fin_q    <= 1'b0;
      ps_q     <= 1'b0;
      fl_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      done_q   <= done_d;
      psh_q    <= psh_d;
      id_q     <= id_d;
      fmask_q  <= fmask_d;
      fid_q    <= fid_d;
      fin_q    <= fin_d;
      ps_q     <= ps_d;
      fl_q     <= fl_d;
      to_q     <= to_d;
    end
  end

  assign state_o     = state_q;
  assign finished_o  = fin_q;
  assign pass_o      = ps_q;
  assign fail_o      = fl_q;
  assign timeout_o   = to_q;
  assign fail_mask_o = fmask_q;
  assign fail_id_o   = fid_q;
  assign done_mask_o = done_q;
  assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_test_result_monitor.sv
// tb_test_result_monitor: directed and random checks of test_result_monitor.
// Random schedules are scored by an edge-indexed model of the verdict rules.
module tb_test_result_monitor;

  localparam int MAXE = 310;
  localparam int INF  = 1000000;
  localparam int S    = 2;
  localparam int T1   = 300;
  localparam int T4   = 50;

  logic clk = 1'b0;
  logic rstn;
  logic clr;
  logic sel4;

  logic         we1;
  logic [4:0]   ad1;
  logic [31:0]  dt1;
  logic [3:0]   we4;
  logic [19:0]  ad4;
  logic [127:0] dt4;

  logic [2:0]  st1, st4;
  logic        fin1, fin4, ps1, ps4;
  logic        fl1, fl4, to1, to4;
  logic [0:0]  fm1, dm1;
  logic [3:0]  fm4, dm4;
  logic [31:0] fid1, fid4, cnt1, cnt4;

  logic [2:0]  o_st;
  logic        o_fin, o_ps, o_fl, o_to;
  logic [3:0]  o_fm, o_dm;
  logic [31:0] o_fid, o_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic        sch_we [0:MAXE][0:3];
  logic [4:0]  sch_ad [0:MAXE][0:3];
  logic [31:0] sch_dt [0:MAXE][0:3];

  int          m_D, m_end, m_state, m_cnt;
  bit          m_to;
  logic [3:0]  m_fmask, m_dmask;
  logic [31:0] m_fid;

  test_result_monitor #(
    .NUM_HART(1), .SETTLE_CYC(S),
    .TIMEOUT_CYC(T1)
  ) u1 (
    .clk(clk), .rstn(rstn), .clr_i(clr),
    .wb_we_i(we1), .wb_waddr_i(ad1),
    .wb_wdata_i(dt1), .state_o(st1),
    .finished_o(fin1), .pass_o(ps1),
    .fail_o(fl1), .timeout_o(to1),
    .fail_mask_o(fm1), .fail_id_o(fid1),
    .done_mask_o(dm1), .cycle_cnt_o(cnt1)
  );

  test_result_monitor #(
    .NUM_HART(4), .SETTLE_CYC(S),
    .TIMEOUT_CYC(T4)
  ) u4 (
    .clk(clk), .rstn(rstn), .clr_i(clr),
    .wb_we_i(we4), .wb_waddr_i(ad4),
    .wb_wdata_i(dt4), .state_o(st4),
    .finished_o(fin4), .pass_o(ps4),
    .fail_o(fl4), .timeout_o(to4),
    .fail_mask_o(fm4), .fail_id_o(fid4),
    .done_mask_o(dm4), .cycle_cnt_o(cnt4)
  );

  always #5 clk = ~clk;

  always_comb begin
    o_st  = sel4 ? st4  : st1;
    o_fin = sel4 ? fin4 : fin1;
    o_ps  = sel4 ? ps4  : ps1;
    o_fl  = sel4 ? fl4  : fl1;
    o_to  = sel4 ? to4  : to1;
    o_fm  = sel4 ? fm4  : {3'b000, fm1};
    o_dm  = sel4 ? dm4  : {3'b000, dm1};
    o_fid = sel4 ? fid4 : fid1;
    o_cnt = sel4 ? cnt4 : cnt1;
  end

  task automatic clear_sched;
    for (int k = 0; k <= MAXE; k++)
      for (int h = 0; h < 4; h++) begin
        sch_we[k][h] = 1'b0;
        sch_ad[k][h] = '0;
        sch_dt[k][h] = '0;
      end
  endtask

  task automatic put(input int k, input int h,
                     input int a, input int d);
    sch_we[k][h] = 1'b1;
    sch_ad[k][h] = 5'(a);
    sch_dt[k][h] = 32'(d);
  endtask

  task automatic zero_inputs;
    we1 = 1'b0; ad1 = '0; dt1 = '0;
    we4 = '0;   ad4 = '0; dt4 = '0;
  endtask

  // Presents the writes of edge k, then returns at the next negedge.
  task automatic drive_edge(input int k);
    zero_inputs();
    for (int h = 0; h < 4; h++) begin
      if (sel4) begin
        we4[h]          = sch_we[k][h];
        ad4[5*h +: 5]   = sch_ad[k][h];
        dt4[32*h +: 32] = sch_dt[k][h];
      end else if (h == 0) begin
        we1 = sch_we[k][0];
        ad1 = sch_ad[k][0];
        dt1 = sch_dt[k][0];
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear;
    clear_sched();
    zero_inputs();
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic gen_random;
    for (int k = 1; k <= MAXE; k++)
      for (int h = 0; h < 4; h++) begin
        sch_we[k][h] = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 5))
          0: begin
            sch_ad[k][h] = 5'd0;
            sch_dt[k][h] = $urandom;
          end
          1: begin
            sch_ad[k][h] = 5'd3;
            sch_dt[k][h] = 32'($urandom_range(0, 255));
          end
          2: begin
            sch_ad[k][h] = 5'd26;
            sch_dt[k][h] = ($urandom_range(0, 3) == 0) ?
              32'($urandom_range(0, 7)) : 32'd1;
          end
          3: begin
            sch_ad[k][h] = 5'd27;
            sch_dt[k][h] = ($urandom_range(0, 4) < 3) ?
              32'd1 : 32'($urandom_range(0, 2));
          end
          default: begin
            sch_ad[k][h] = 5'($urandom_range(0, 31));
            sch_dt[k][h] = $urandom;
          end
        endcase
      end
  endtask

  // Verdict from the schedule: edge of the last first-done, settle
  // window, timeout edge, and last-write-wins shadows up to the end edge.
  task automatic model_eval(input int nh, input int tlim);
    int          de [4];
    logic [3:0]  pf;
    logic [31:0] idv [4];
    int          dmax;
    bit          allp;
    dmax = 0;
    for (int h = 0; h < 4; h++) begin
      de[h] = INF; pf[h] = 1'b0; idv[h] = '0;
    end
    for (int k = 1; k <= MAXE; k++)
      for (int h = 0; h < nh; h++)
        if (de[h] == INF && sch_we[k][h] &&
            sch_ad[k][h] == 5'd26 &&
            sch_dt[k][h] == 32'd1)
          de[h] = k;
    for (int h = 0; h < nh; h++)
      if (de[h] > dmax) dmax = de[h];
    m_D   = dmax;
    m_to  = (dmax + S >= tlim);
    m_end = m_to ? tlim : dmax + S;
    for (int k = 1; k <= m_end; k++)
      for (int h = 0; h < nh; h++)
        if (sch_we[k][h]) begin
          if (sch_ad[k][h] == 5'd3)
            idv[h] = sch_dt[k][h];
          if (sch_ad[k][h] == 5'd27)
            pf[h] = (sch_dt[k][h] == 32'd1);
        end
    allp = 1'b1;
    m_dmask = '0; m_fmask = '0; m_fid = '0;
    for (int h = 0; h < nh; h++) begin
      m_dmask[h] = (de[h] <= m_end);
      if (!pf[h]) allp = 1'b0;
    end
    if (m_to) begin
      m_state = 4;
      m_cnt   = tlim - 1;
    end else begin
      m_cnt = m_end;
      if (allp) begin
        m_state = 2;
      end else begin
        m_state = 3;
        for (int h = nh - 1; h >= 0; h--)
          if (!pf[h]) begin
            m_fmask[h] = 1'b1;
            m_fid      = idv[h];
          end
      end
    end
  endtask

  task automatic test_reset;
    tests_run++;
    if (st1 !== 3'd0 || st4 !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state got %0d/%0d want 0",
               st1, st4);
    end
    tests_run++;
    if (cnt1 !== 32'd0 || cnt4 !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt got %0d/%0d want 0",
               cnt1, cnt4);
    end
    tests_run++;
    if ({fin1, ps1, fl1, to1, fin4, ps4, fl4, to4} !== 8'd0 ||
        dm4 !== 4'd0 || fm4 !== 4'd0 || fid4 !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_flags got nonzero want 0");
    end
  endtask

  task automatic test_pass;
    sel4 = 1'b0;
    do_clear();
    put(50, 0, 27, 1);
    put(100, 0, 26, 1);
    for (int k = 1; k <= 106; k++) begin
      drive_edge(k);
      if (k == 99) begin
        tests_run++;
        if (o_st !== 3'd0) begin
          tests_failed++;
          $display("FAIL pass_run got %0d want 0", o_st);
        end
      end
      if (k == 101) begin
        tests_run++;
        if (o_st !== 3'd1 || o_cnt !== 32'd101) begin
          tests_failed++;
          $display("FAIL pass_settle got %0d/%0d want 1/101",
                   o_st, o_cnt);
        end
      end
      if (k == 102) begin
        tests_run++;
        if (o_st !== 3'd2 || o_ps !== 1'b1 || o_fin !== 1'b1) begin
          tests_failed++;
          $display("FAIL pass_edge got %0d/%0b want 2/1",
                   o_st, o_ps);
        end
      end
    end
    tests_run++;
    if (o_cnt !== 32'd102) begin
      tests_failed++;
      $display("FAIL pass_cnt got %0d want 102", o_cnt);
    end
    tests_run++;
    if (o_fl !== 1'b0 || o_to !== 1'b0 ||
        o_fm !== 4'd0 || o_dm !== 4'd1) begin
      tests_failed++;
      $display("FAIL pass_misc got fl%0b to%0b fm%0h dm%0h",
               o_fl, o_to, o_fm, o_dm);
    end
  endtask

  task automatic test_fail;
    sel4 = 1'b0;
    do_clear();
    put(5, 0, 3, 7);
    put(6, 0, 27, 0);
    put(10, 0, 26, 1);
    for (int k = 1; k <= 16; k++) drive_edge(k);
    tests_run++;
    if (o_st !== 3'd3 || o_fl !== 1'b1 ||
        o_ps !== 1'b0 || o_fin !== 1'b1) begin
      tests_failed++;
      $display("FAIL fail_state got %0d want 3", o_st);
    end
    tests_run++;
    if (o_fm !== 4'd1 || o_fid !== 32'd7) begin
      tests_failed++;
      $display("FAIL fail_id got %0h/%0d want 1/7",
               o_fm, o_fid);
    end
    tests_run++;
    if (o_cnt !== 32'd12) begin
      tests_failed++;
      $display("FAIL fail_cnt got %0d want 12", o_cnt);
    end
  endtask

  task automatic test_late_pass;
    sel4 = 1'b0;
    do_clear();
    put(2, 0, 27, 0);
    put(3, 0, 26, 5);
    put(4, 0, 0, 1);
    put(8, 0, 26, 1);
    put(9, 0, 27, 1);
    put(11, 0, 27, 0);
    put(12, 0, 3, 99);
    for (int k = 1; k <= 16; k++) begin
      drive_edge(k);
      if (k == 6) begin
        tests_run++;
        if (o_dm !== 4'd0 || o_st !== 3'd0) begin
          tests_failed++;
          $display("FAIL late_ignore got dm%0h st%0d want 0/0",
                   o_dm, o_st);
        end
      end
      if (k == 9) begin
        tests_run++;
        if (o_st !== 3'd1) begin
          tests_failed++;
          $display("FAIL late_settle got %0d want 1", o_st);
        end
      end
    end
    tests_run++;
    if (o_st !== 3'd2 || o_ps !== 1'b1 || o_fl !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_pass got %0d want 2", o_st);
    end
    tests_run++;
    if (o_fid !== 32'd0 || o_fm !== 4'd0 ||
        o_cnt !== 32'd10) begin
      tests_failed++;
      $display("FAIL late_hold got fid%0d cnt%0d want 0/10",
               o_fid, o_cnt);
    end
  endtask

  task automatic test_multi_hart;
    int ids [4];
    int pv  [4];
    ids = '{100, 11, 22, 33};
    pv  = '{1, 0, 1, 0};
    sel4 = 1'b1;
    do_clear();
    for (int h = 0; h < 4; h++) begin
      put(2, h, 3, ids[h]);
      put(5, h, 27, pv[h]);
      put(10 * (h + 1), h, 26, 1);
    end
    for (int k = 1; k <= 46; k++) begin
      drive_edge(k);
      if (k == 39) begin
        tests_run++;
        if (o_st !== 3'd0 || o_dm !== 4'b0111) begin
          tests_failed++;
          $display("FAIL multi_run got st%0d dm%0h want 0/7",
                   o_st, o_dm);
        end
      end
      if (k == 41) begin
        tests_run++;
        if (o_st !== 3'd1 || o_dm !== 4'hF) begin
          tests_failed++;
          $display("FAIL multi_settle got st%0d dm%0h want 1/f",
                   o_st, o_dm);
        end
      end
    end
    tests_run++;
    if (o_st !== 3'd3 || o_fm !== 4'b1010) begin
      tests_failed++;
      $display("FAIL multi_mask got st%0d fm%0h want 3/a",
               o_st, o_fm);
    end
    tests_run++;
    if (o_fid !== 32'd11 || o_cnt !== 32'd42 ||
        o_dm !== 4'hF) begin
      tests_failed++;
      $display("FAIL multi_id got fid%0d cnt%0d want 11/42",
               o_fid, o_cnt);
    end
  endtask

  task automatic test_timeout;
    sel4 = 1'b1;
    do_clear();
    put(3, 1, 3, 5);
    for (int k = 1; k <= 55; k++) begin
      drive_edge(k);
      if (k == 49) begin
        tests_run++;
        if (o_st !== 3'd0 || o_cnt !== 32'd49) begin
          tests_failed++;
          $display("FAIL to_pre got st%0d cnt%0d want 0/49",
                   o_st, o_cnt);
        end
      end
      if (k == 50) begin
        tests_run++;
        if (o_st !== 3'd4 || o_to !== 1'b1) begin
          tests_failed++;
          $display("FAIL to_edge got st%0d want 4", o_st);
        end
      end
    end
    tests_run++;
    if (o_cnt !== 32'd49 || o_fin !== 1'b1 ||
        o_ps !== 1'b0 || o_fl !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_hold got cnt%0d want 49", o_cnt);
    end
    tests_run++;
    if (o_fm !== 4'd0 || o_fid !== 32'd0) begin
      tests_failed++;
      $display("FAIL to_mask got fm%0h fid%0d want 0/0",
               o_fm, o_fid);
    end
  endtask

  task automatic test_timeout_coincident;
    for (int v = 0; v < 2; v++) begin
      sel4 = 1'b1;
      do_clear();
      for (int h = 0; h < 4; h++) begin
        put(3, h, 27, 1);
        put(50 - v, h, 26, 1);
      end
      for (int k = 1; k <= 54; k++) begin
        drive_edge(k);
        if (v == 1 && k == 49) begin
          tests_run++;
          if (o_st !== 3'd1) begin
            tests_failed++;
            $display("FAIL to_settle got %0d want 1", o_st);
          end
        end
      end
      tests_run++;
      if (o_st !== 3'd4 || o_ps !== 1'b0 ||
          o_cnt !== 32'd49) begin
        tests_failed++;
        $display("FAIL to_coinc%0d got st%0d cnt%0d want 4/49",
                 v, o_st, o_cnt);
      end
    end
  endtask

  task automatic test_reset_settle;
    sel4 = 1'b0;
    do_clear();
    put(1, 0, 27, 1);
    put(5, 0, 26, 1);
    for (int k = 1; k <= 5; k++) drive_edge(k);
    tests_run++;
    if (o_st !== 3'd1) begin
      tests_failed++;
      $display("FAIL rst_pre got %0d want 1", o_st);
    end
    #2;
    zero_inputs();
    rstn = 1'b0;
    #1;
    tests_run++;
    if (o_st !== 3'd0 || o_cnt !== 32'd0 ||
        o_dm !== 4'd0 || o_fin !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async got st%0d cnt%0d want 0/0",
               o_st, o_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    clear_sched();
    for (int k = 1; k <= 5; k++) drive_edge(k);
    tests_run++;
    if (o_st !== 3'd0 || o_cnt !== 32'd5 ||
        o_fin !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_post got st%0d cnt%0d want 0/5",
               o_st, o_cnt);
    end
  endtask

  task automatic test_clear;
    sel4 = 1'b0;
    do_clear();
    put(1, 0, 27, 1);
    put(2, 0, 26, 1);
    for (int k = 1; k <= 6; k++) drive_edge(k);
    tests_run++;
    if (o_st !== 3'd2) begin
      tests_failed++;
      $display("FAIL clr_pre got %0d want 2", o_st);
    end
    we1 = 1'b1; ad1 = 5'd26; dt1 = 32'd1;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    zero_inputs();
    tests_run++;
    if (o_st !== 3'd0 || o_cnt !== 32'd0 ||
        o_dm !== 4'd0 || o_ps !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_now got st%0d cnt%0d dm%0h want 0",
               o_st, o_cnt, o_dm);
    end
    clear_sched();
    for (int k = 1; k <= 3; k++) drive_edge(k);
    tests_run++;
    if (o_st !== 3'd0 || o_cnt !== 32'd3) begin
      tests_failed++;
      $display("FAIL clr_post got st%0d cnt%0d want 0/3",
               o_st, o_cnt);
    end
  endtask

  task automatic test_random;
    int nh;
    int tl;
    int es;
    int ec;
    for (int it = 0; it < 16; it++) begin
      sel4 = it[0];
      nh = sel4 ? 4 : 1;
      tl = sel4 ? T4 : T1;
      do_clear();
      gen_random();
      model_eval(nh, tl);
      for (int k = 1; k <= m_end + 4; k++) begin
        drive_edge(k);
        es = (k >= m_end) ? m_state : ((k >= m_D) ? 1 : 0);
        ec = (k >= m_end) ? m_cnt : k;
        tests_run++;
        if (o_st !== 3'(es) || o_cnt !== 32'(ec)) begin
          tests_failed++;
          $display("FAIL rnd%0d_e%0d got st%0d cnt%0d want %0d/%0d",
                   it, k, o_st, o_cnt, es, ec);
        end
      end
      tests_run++;
      if (o_fin !== 1'b1 || o_ps !== (m_state == 2) ||
          o_fl !== (m_state == 3) || o_to !== m_to) begin
        tests_failed++;
        $display("FAIL rnd%0d_flags got %0b%0b%0b want st%0d",
                 it, o_ps, o_fl, o_to, m_state);
      end
      tests_run++;
      if (o_fm !== m_fmask || o_fid !== m_fid) begin
        tests_failed++;
        $display("FAIL rnd%0d_fail got %0h/%0h want %0h/%0h",
                 it, o_fm, o_fid, m_fmask, m_fid);
      end
      if (!m_to) begin
        tests_run++;
        if (o_dm !== m_dmask) begin
          tests_failed++;
          $display("FAIL rnd%0d_done got %0h want %0h",
                   it, o_dm, m_dmask);
        end
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    clr  = 1'b0;
    sel4 = 1'b0;
    zero_inputs();
    clear_sched();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rstn = 1'b1;
    test_pass();
    test_fail();
    test_late_pass();
    test_multi_hart();
    test_timeout();
    test_timeout_coincident();
    test_reset_settle();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

endmodule
